// File: rtl/mem_arbiter_pkg.sv
// Shared types and width defaults for the fetch/data memory arbiter and the
// pipeline that feeds it.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared-memory port signals.
// master = requesters plus memory (the environment); slave = the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output busy
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Winner select between fetch and data requests, with a starvation counter
// that hands the slot to fetch after STARVE_MAX back-to-back data grants.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic grant_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic             fetch_turn;

    assign fetch_turn = if_req && (starve_cnt_reg == CNT_MAX);

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (grant_en) begin
            if (dm_req && !fetch_turn) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Count only data wins that actually made fetch wait.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_gnt) begin
            starve_cnt_next = '0;
        end else if (dm_gnt && starve_cnt_reg != CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-outstanding memory between instruction
// fetch and load/store, with registered request fields and response strobes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input logic          clk1,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    state_t            state_reg, state_next;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;
    logic              if_rvalid_reg, dm_rvalid_reg;
    logic              if_gnt, dm_gnt, grant, grant_en, ack_done;

    assign grant_en = (state_reg == IDLE);
    assign grant    = if_gnt | dm_gnt;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_prio (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .grant_en (grant_en),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
        .if_gnt   (if_gnt),
        .dm_gnt   (dm_gnt)
    );

    always_comb begin
        state_next = state_reg;
        ack_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                    ack_done   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_IF;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_rvalid_reg <= 1'b0;
            dm_rvalid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            if_rvalid_reg <= ack_done && (owner_reg == OWN_IF);
            dm_rvalid_reg <= ack_done && (owner_reg == OWN_DM);
            if (grant) begin
                owner_reg <= dm_gnt ? OWN_DM : OWN_IF;
                addr_reg  <= dm_gnt ? bus.dm_addr : bus.if_addr;
                we_reg    <= dm_gnt & bus.dm_we;
                wdata_reg <= dm_gnt ? bus.dm_wdata : '0;
            end
            // Writes complete without touching the load data register.
            if (ack_done && !we_reg) begin
                if (owner_reg == OWN_IF) begin
                    if_rdata_reg <= bus.mem_rdata;
                end else begin
                    dm_rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.dm_rvalid = dm_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.mem_req   = (state_reg == BUSY);
    assign bus.mem_we    = (state_reg == BUSY) & we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter: reset, single fetch, store,
// starvation order, reset mid-transaction, stray ack and a back-to-back run.
module tb_mem_arbiter;

    localparam int NTX = 200;

    logic clk1;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] mem_model [0:1023];

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .STARVE_MAX (3)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic smp();
        @(negedge clk1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        smp(); smp();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        total++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got if=%b dm=%b expected 0 0", bus.if_rvalid, bus.dm_rvalid); end
        total++; if (bus.mem_addr !== 10'h000) begin bad++; $display("FAIL reset_mem_addr: got %h expected 000", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        total++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got if=%h dm=%h expected 0 0", bus.if_rdata, bus.dm_rdata); end
        cyc();
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_single_fetch();
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 10'h005;
        smp();
        total++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt: got if=%b dm=%b expected 1 0", bus.if_gnt, bus.dm_gnt); end
        cyc();
        bus.if_req = 1'b0; bus.if_addr = 10'h3FF;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2800000A;
        smp();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h005 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL fetch_mem: got req=%b addr=%h we=%b expected 1 005 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fetch_busy: got %b expected 1", bus.busy); end
        cyc();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEADBEEF;
        smp();
        total++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h2800000A) begin bad++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h expected 1 2800000a", bus.if_rvalid, bus.if_rdata); end
        total++; if (bus.dm_rvalid !== 1'b0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL fetch_after: got dm_rvalid=%b mem_req=%b busy=%b expected 0 0 0", bus.dm_rvalid, bus.mem_req, bus.busy); end
        cyc();
        smp();
        total++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h2800000A) begin bad++; $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 2800000a", bus.if_rvalid, bus.if_rdata); end
        $display("single_fetch: addr=005 data=2800000a");
    endtask

    task automatic test_store();
        int pulses = 0;
        cyc();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h3F0; bus.dm_wdata = 32'h12345678;
        smp();
        total++; if (bus.dm_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin bad++; $display("FAIL store_gnt: got dm=%b if=%b expected 1 0", bus.dm_gnt, bus.if_gnt); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 10'h111; bus.dm_wdata = 32'hFFFFFFFF;
            bus.mem_ack = (i == 3); bus.mem_rdata = 32'hCAFEF00D;
            smp();
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h3F0 || bus.mem_wdata !== 32'h12345678) begin
                bad++;
                $display("FAIL store_fields[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1 1 3f0 12345678", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
            if (bus.dm_rvalid) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.mem_ack = 1'b0;
            smp();
            if (bus.dm_rvalid) pulses++;
            if (i == 0) begin
                total++; if (bus.dm_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0) begin bad++; $display("FAIL store_rvalid: got dm=%b if=%b expected 1 0", bus.dm_rvalid, bus.if_rvalid); end
                total++; if (bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL store_rdata: got %h expected 00000000", bus.dm_rdata); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL store_pulses: got %0d expected 1", pulses); end
        $display("store: addr=3f0 data=12345678 pulses=%0d", pulses);
    endtask

    task automatic test_contention();
        logic [7:0] exp_order;
        int k = 0;
        int n = 0;
        exp_order = 8'b1000_1000;
        bus.dm_we = 1'b0; bus.dm_addr = 10'h020; bus.if_addr = 10'h010;
        while (k < 8 && n < 60) begin
            cyc();
            if (n == 0) begin bus.if_req = 1'b1; bus.dm_req = 1'b1; end
            bus.mem_ack = bus.mem_req;
            bus.mem_rdata = 32'h00C0FFEE;
            n++;
            smp();
            if (bus.if_gnt || bus.dm_gnt) begin
                total++;
                if (bus.if_gnt !== exp_order[k] || bus.dm_gnt !== !exp_order[k]) begin
                    bad++;
                    $display("FAIL contention[%0d]: got if=%b dm=%b expected if=%b dm=%b", k, bus.if_gnt, bus.dm_gnt, exp_order[k], !exp_order[k]);
                end
                $display("contention: grant %0d to %s", k, bus.if_gnt ? "IF" : "DM");
                k++;
            end
        end
        total++; if (k !== 8) begin bad++; $display("FAIL contention_timeout: got %0d grants expected 8", k); end
        cyc();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        bus.mem_ack = bus.mem_req;
        cyc();
        bus.mem_ack = 1'b0;
        smp();
        total++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00C0FFEE) begin bad++; $display("FAIL contention_last: got rvalid=%b rdata=%h expected 1 00c0ffee", bus.if_rvalid, bus.if_rdata); end
        cyc();
        smp();
    endtask

    task automatic test_reset_mid_op();
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 10'h0AB;
        smp();
        total++; if (bus.if_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt: got %b expected 1", bus.if_gnt); end
        cyc();
        bus.if_req = 1'b0;
        smp();
        total++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h0AB) begin bad++; $display("FAIL rstmid_busy: got busy=%b req=%b addr=%h expected 1 1 0ab", bus.busy, bus.mem_req, bus.mem_addr); end
        cyc();
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 10'h000) begin bad++; $display("FAIL rstmid_async: got req=%b busy=%b addr=%h expected 0 0 000", bus.mem_req, bus.busy, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        smp();
        cyc();
        bus.mem_ack = 1'b0;
        smp();
        total++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_norv: got if=%b dm=%b if_rdata=%h expected 0 0 0", bus.if_rvalid, bus.dm_rvalid, bus.if_rdata); end
        cyc();
        rst_n = 1'b1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h001; bus.dm_wdata = 32'hA5A5A5A5;
        smp();
        total++; if (bus.dm_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_regrant: got %b expected 1", bus.dm_gnt); end
        cyc();
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.mem_ack = bus.mem_req;
        cyc();
        bus.mem_ack = 1'b0;
        smp();
        total++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_write: got rvalid=%b rdata=%h expected 1 0", bus.dm_rvalid, bus.dm_rdata); end
        cyc();
        smp();
        $display("reset_mid_op: aborted fetch 0ab, regranted store 001");
    endtask

    task automatic test_stray_ack();
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
            smp();
            total++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL stray_idle[%0d]: got busy=%b req=%b expected 0 0", i, bus.busy, bus.mem_req); end
        end
        cyc();
        bus.mem_ack = 1'b0;
        smp();
        total++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin bad++; $display("FAIL stray_rvalid: got if=%b dm=%b expected 0 0", bus.if_rvalid, bus.dm_rvalid); end
        total++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL stray_rdata: got if=%h dm=%h expected 0 0", bus.if_rdata, bus.dm_rdata); end
        $display("stray_ack: ignored");
    endtask

    task automatic test_random();
        int grants = 0;
        int responses = 0;
        int cycles = 0;
        int wait_cnt = 0;
        logic pend_valid = 1'b0;
        logic pend_dm = 1'b0;
        logic pend_we = 1'b0;
        logic [9:0] pend_addr = '0;
        logic [31:0] pend_wdata = '0;
        logic [31:0] pend_exp = '0;
        logic rv_if_next = 1'b0;
        logic rv_dm_next = 1'b0;
        logic [31:0] exp_if_data = 32'h0;
        logic [31:0] exp_dm_data = 32'h0;
        logic if_granted = 1'b0;
        logic dm_granted = 1'b0;
        logic exp_idle;
        for (int a = 0; a < 1024; a++) mem_model[a] = $urandom;
        while ((grants < NTX || pend_valid || rv_if_next || rv_dm_next || bus.if_req || bus.dm_req) && cycles < 20000) begin
            cyc();
            if (if_granted || (bus.if_req && $urandom_range(0, 15) == 0)) bus.if_req = 1'b0;
            if (dm_granted || (bus.dm_req && $urandom_range(0, 15) == 0)) bus.dm_req = 1'b0;
            if (!bus.if_req && grants < NTX && $urandom_range(0, 1) == 1) begin
                bus.if_req = 1'b1; bus.if_addr = 10'($urandom_range(0, 15));
            end
            if (!bus.dm_req && grants < NTX && $urandom_range(0, 1) == 1) begin
                bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
                bus.dm_addr = 10'($urandom_range(0, 15)); bus.dm_wdata = $urandom;
            end
            if_granted = 1'b0;
            dm_granted = 1'b0;
            if (bus.mem_req) begin
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = mem_model[bus.mem_addr];
                end else begin
                    wait_cnt--; bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_ack = ($urandom_range(0, 7) == 0); bus.mem_rdata = $urandom;
            end
            smp();
            cycles++;
            exp_idle = !pend_valid;
            total++; if (bus.if_rvalid !== rv_if_next) begin bad++; $display("FAIL rnd_if_rvalid @%0d: got %b expected %b", cycles, bus.if_rvalid, rv_if_next); end
            total++; if (bus.dm_rvalid !== rv_dm_next) begin bad++; $display("FAIL rnd_dm_rvalid @%0d: got %b expected %b", cycles, bus.dm_rvalid, rv_dm_next); end
            total++; if (bus.if_rvalid && bus.dm_rvalid) begin bad++; $display("FAIL rnd_both_rvalid @%0d: got 1 1 expected at most one", cycles); end
            total++; if (bus.if_rdata !== exp_if_data) begin bad++; $display("FAIL rnd_if_rdata @%0d: got %h expected %h", cycles, bus.if_rdata, exp_if_data); end
            total++; if (bus.dm_rdata !== exp_dm_data) begin bad++; $display("FAIL rnd_dm_rdata @%0d: got %h expected %h", cycles, bus.dm_rdata, exp_dm_data); end
            if (bus.if_rvalid || bus.dm_rvalid) responses++;
            rv_if_next = 1'b0;
            rv_dm_next = 1'b0;
            total++; if (bus.busy !== pend_valid || bus.mem_req !== pend_valid) begin bad++; $display("FAIL rnd_busy @%0d: got busy=%b req=%b expected %b", cycles, bus.busy, bus.mem_req, pend_valid); end
            if (pend_valid) begin
                total++;
                if (bus.mem_addr !== pend_addr || bus.mem_we !== pend_we || (pend_we && bus.mem_wdata !== pend_wdata)) begin
                    bad++;
                    $display("FAIL rnd_mem_fields @%0d: got addr=%h we=%b wdata=%h expected %h %b %h", cycles, bus.mem_addr, bus.mem_we, bus.mem_wdata, pend_addr, pend_we, pend_wdata);
                end
                if (bus.mem_ack) begin
                    if (pend_dm) begin
                        rv_dm_next = 1'b1;
                        if (!pend_we) exp_dm_data = pend_exp;
                    end else begin
                        rv_if_next = 1'b1;
                        exp_if_data = pend_exp;
                    end
                    if (pend_we) mem_model[pend_addr] = pend_wdata;
                    pend_valid = 1'b0;
                end
            end
            total++;
            if ((bus.if_gnt | bus.dm_gnt) !== (exp_idle && (bus.if_req || bus.dm_req)) || (bus.if_gnt && bus.dm_gnt)) begin
                bad++;
                $display("FAIL rnd_gnt @%0d: got if=%b dm=%b expected one grant=%b", cycles, bus.if_gnt, bus.dm_gnt, exp_idle && (bus.if_req || bus.dm_req));
            end
            if (bus.dm_gnt) begin
                pend_valid = 1'b1; pend_dm = 1'b1; pend_we = bus.dm_we;
                pend_addr = bus.dm_addr; pend_wdata = bus.dm_wdata;
                pend_exp = mem_model[bus.dm_addr];
                dm_granted = 1'b1; grants++; wait_cnt = $urandom_range(0, 3);
                $display("random: tx %0d DM %s addr=%h", grants, bus.dm_we ? "W" : "R", bus.dm_addr);
            end else if (bus.if_gnt) begin
                pend_valid = 1'b1; pend_dm = 1'b0; pend_we = 1'b0;
                pend_addr = bus.if_addr; pend_wdata = '0;
                pend_exp = mem_model[bus.if_addr];
                if_granted = 1'b1; grants++; wait_cnt = $urandom_range(0, 3);
                $display("random: tx %0d IF R addr=%h", grants, bus.if_addr);
            end
        end
        total++; if (cycles >= 20000) begin bad++; $display("FAIL rnd_timeout: got %0d cycles expected fewer than 20000", cycles); end
        total++; if (responses !== grants) begin bad++; $display("FAIL rnd_count: got %0d responses expected %0d", responses, grants); end
        total++; if (grants < NTX) begin bad++; $display("FAIL rnd_grants: got %0d expected at least %0d", grants, NTX); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_reset_mid_op();
        test_stray_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
